led_sched_m: RTL and testbench

//   Time-slicing scheduler that shares the 8-bit LED bank between N_REQ pattern sources.

---
 rtl/led_sched_pkg.sv | 26 ++
 rtl/rr_pick_m.sv | 27 ++
 rtl/led_sched_m.sv | 135 +++++++++++++
 tb/tb_led_sched_m.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// Shared types and the round-robin next-index helper for the LED scheduler.
package led_sched_pkg;

  localparam int unsigned MaxReq = 8;
  localparam int unsigned RrIdxW = 3;

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  // First requesting index strictly after last, wrapping within n sources; returns last if none.
  function automatic logic [RrIdxW-1:0] rr_next(input logic [MaxReq-1:0] req,
                                                input logic [RrIdxW-1:0] last,
                                                input int unsigned n);
    logic [RrIdxW-1:0] win;
    logic [RrIdxW-1:0] cand;
    win = last;
    // Walk from farthest to nearest so the nearest requester is written last and wins.
    for (int k = MaxReq; k >= 1; k--) begin
      cand = RrIdxW'((int'(last) + k) % int'(n));
      if ((k <= int'(n)) && req[cand]) begin
        win = cand;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_pick_m.sv
// Combinational round-robin picker: one-hot winner, its index and an any-request flag.
module rr_pick_m
  import led_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]  req_i,
  input  logic [RrIdxW-1:0] last_i,
  output logic [N_REQ-1:0]  gnt_o,
  output logic [RrIdxW-1:0] idx_o,
  output logic              any_o
);

  logic [MaxReq-1:0] req_ext;

  assign req_ext = MaxReq'(req_i);
  assign any_o   = |req_i;
  assign idx_o   = rr_next(req_ext, last_i, N_REQ);

  always_comb begin
    gnt_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      gnt_o[k] = any_o && (idx_o == RrIdxW'(k));
    end
  end

endmodule

// File: rtl/led_sched_m.sv
// Time-slicing round-robin scheduler sharing the LED bank between N_REQ pattern sources.
// Define LED_SCHED_PREEMPT_EN to let source 0 preempt any other holder.
module led_sched_m #(
  parameter int unsigned      N_REQ        = 4,
  parameter int unsigned      LED_W        = 8,
  parameter int unsigned      DWELL_W      = 24,
  parameter logic [LED_W-1:0] IDLE_PATTERN = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DWELL_W-1:0]     i_dwell,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*LED_W-1:0] i_pattern,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [LED_W-1:0]       o_led,
  output logic                   o_busy,
  output logic                   o_slice_done
);
  import led_sched_pkg::*;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [RrIdxW-1:0]  last_q, last_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d, dwell_load;
  logic [LED_W-1:0]   led_q, led_d, hold_pat, pick_pat;
  logic               busy_q, busy_d, done_q, done_d;
  logic [N_REQ-1:0]   pick_gnt;
  logic [RrIdxW-1:0]  pick_idx;
  logic               pick_any, holder_req, preempt;

  // While holding, last_q is the holder index, so one picker serves both start and hand-over.
  rr_pick_m #(
    .N_REQ(N_REQ)
  ) u_rr_pick (
    .req_i (i_req),
    .last_i(last_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign dwell_load = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);
  assign holder_req = |(i_req & gnt_q);

`ifdef LED_SCHED_PREEMPT_EN
  assign preempt = i_req[0] & ~gnt_q[0];
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    hold_pat = '0;
    pick_pat = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_q[k]) hold_pat |= i_pattern[k*LED_W +: LED_W];
      if (pick_gnt[k]) pick_pat |= i_pattern[k*LED_W +: LED_W];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        led_d = IDLE_PATTERN;
        if (pick_any) begin
          state_d = StHold;
          gnt_d   = pick_gnt;
          last_d  = pick_idx;
          cnt_d   = dwell_load;
          led_d   = pick_pat;
          busy_d  = 1'b1;
        end
      end
      StHold: begin
        if (preempt) begin
          gnt_d  = N_REQ'(1);
          last_d = '0;
          cnt_d  = dwell_load;
          led_d  = i_pattern[LED_W-1:0];
        end else if (holder_req && (cnt_q != '0)) begin
          cnt_d = cnt_q - DWELL_W'(1);
          led_d = hold_pat;
        end else begin
          // Expiry and early release share re-arbitration; only expiry reports slice_done.
          done_d = holder_req;
          if (pick_any) begin
            gnt_d  = pick_gnt;
            last_d = pick_idx;
            cnt_d  = dwell_load;
            led_d  = pick_pat;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
            cnt_d   = '0;
            led_d   = IDLE_PATTERN;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      last_q  <= RrIdxW'(N_REQ - 1);
      cnt_q   <= '0;
      led_q   <= IDLE_PATTERN;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_gnt        = gnt_q;
  assign o_led        = led_q;
  assign o_busy       = busy_q;
  assign o_slice_done = done_q;

endmodule

// File: tb/tb_led_sched_m.sv
// Bench for led_sched_m: directed table, hand-written corner sequences, random vs. slice model.
module tb_led_sched_m;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] dwell = '0;
  logic [3:0]  req = '0;
  logic [7:0]  pat [4];
  logic [31:0] pattern_bus;
  logic [3:0]  gnt;
  logic [7:0]  led;
  logic        busy, done;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: holder (-1 = none), cycles spent in slice, slice length.
  int       m_holder, m_last, m_age, m_len;
  logic [7:0] m_led;
  logic     m_done;

  typedef struct {
    logic [3:0]  req;
    logic [23:0] dwell;
    logic [3:0]  gnt;
    logic [7:0]  led;
    logic        busy;
    logic        done;
  } vec_t;
  vec_t tbl [13];

  always #5 clk = ~clk;

  assign pattern_bus = {pat[3], pat[2], pat[1], pat[0]};

  led_sched_m #(
    .N_REQ(4), .LED_W(8), .DWELL_W(24), .IDLE_PATTERN(8'h00)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_dwell     (dwell),
    .i_req       (req),
    .i_pattern   (pattern_bus),
    .o_gnt       (gnt),
    .o_led       (led),
    .o_busy      (busy),
    .o_slice_done(done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_gnt, input logic [7:0] e_led,
                           input logic e_busy, input logic e_done);
    check({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    check({tag, ".led"}, 32'(led), 32'(e_led));
    check({tag, ".busy"}, 32'(busy), 32'(e_busy));
    check({tag, ".done"}, 32'(done), 32'(e_done));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_holder = -1;
    m_last   = N - 1;
    m_age    = 0;
    m_len    = 1;
    m_led    = 8'h00;
    m_done   = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_out("reset", 4'b0000, 8'h00, 1'b0, 1'b0);
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  // One clock edge of the scheduler as seen from the outside.
  task automatic model_step();
    int  w;
    bit  hreq, pre;
    m_done = 1'b0;
    hreq = (m_holder >= 0) && req[m_holder];
    pre  = 1'b0;
`ifdef LED_SCHED_PREEMPT_EN
    pre = (m_holder > 0) && req[0];
`endif
    if (m_holder >= 0 && hreq && !pre && m_age < m_len) begin
      m_age++;
      m_led = pat[m_holder];
    end else begin
      if (m_holder >= 0 && hreq && !pre) m_done = 1'b1;
      w = -1;
      if (pre) w = 0;
      else
        for (int k = N; k >= 1; k--)
          if (req[(m_last + k) % N]) w = (m_last + k) % N;
      if (w < 0) begin
        m_holder = -1;
        m_led    = 8'h00;
      end else begin
        m_holder = w;
        m_last   = w;
        m_age    = 1;
        m_len    = (dwell == 0) ? 1 : int'(dwell);
        m_led    = pat[w];
      end
    end
  endtask

  task automatic set_row(input int i, input logic [3:0] g, input logic [7:0] l, input logic d);
    tbl[i] = '{req: 4'b1111, dwell: 24'd3, gnt: g, led: l, busy: 1'b1, done: d};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    set_row(0, 4'b0001, 8'h11, 0); set_row(1, 4'b0001, 8'h11, 0);
    set_row(2, 4'b0001, 8'h11, 0); set_row(3, 4'b0010, 8'h22, 1);
    set_row(4, 4'b0010, 8'h22, 0); set_row(5, 4'b0010, 8'h22, 0);
    set_row(6, 4'b0100, 8'h33, 1); set_row(7, 4'b0100, 8'h33, 0);
    set_row(8, 4'b0100, 8'h33, 0); set_row(9, 4'b1000, 8'h44, 1);
    set_row(10, 4'b1000, 8'h44, 0); set_row(11, 4'b1000, 8'h44, 0);
    set_row(12, 4'b0001, 8'h11, 1);
    for (int i = 0; i < 4; i++) pat[i] = 8'h00;

    // Single holder, dwell 4: grant persists, slice_done every 4 cycles.
    do_reset();
    dwell = 24'd4; req = 4'b0001; pat[0] = 8'hA5;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_out("solo", 4'b0001, 8'hA5, 1'b1, (i > 1) && ((i - 1) % 4 == 0));
    end

`ifndef LED_SCHED_PREEMPT_EN
    // Full rotation, dwell 3.
    do_reset();
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    for (int i = 0; i < 13; i++) begin
      req = tbl[i].req; dwell = tbl[i].dwell;
      tick();
      check_out("rotate", tbl[i].gnt, tbl[i].led, tbl[i].busy, tbl[i].done);
    end
`endif

    // Early release hands over without slice_done, then idle.
    do_reset();
    dwell = 24'd10; req = 4'b0010;
    tick();
    check_out("early.grant", 4'b0010, 8'h22, 1'b1, 1'b0);
    req = 4'b1010;
    tick(); tick();
    check_out("early.hold", 4'b0010, 8'h22, 1'b1, 1'b0);
    req = 4'b1000;
    tick();
    check_out("early.move", 4'b1000, 8'h44, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    check_out("early.idle", 4'b0000, 8'h00, 1'b0, 1'b0);

    // Dwell 0 behaves as 1-cycle slices with the live pattern one cycle behind.
    do_reset();
    dwell = 24'd0; req = 4'b0100;
    for (int i = 1; i <= 6; i++) begin
      v = 8'($urandom);
      pat[2] = v;
      tick();
      check_out("dwell0", 4'b0100, v, 1'b1, i > 1);
    end

    // Asynchronous reset mid-slice also resets the pointer.
    do_reset();
    dwell = 24'd8; req = 4'b0010;
    tick(); tick(); tick();
    rst = 1'b1;
    #1 check_out("midrst", 4'b0000, 8'h00, 1'b0, 1'b0);
    #1 rst = 1'b0;
    req = 4'b1111;
    tick();
    check_out("midrst.first", 4'b0001, pat[0], 1'b1, 1'b0);

    // Source 0 arriving while source 2 holds.
    do_reset();
    dwell = 24'd8; req = 4'b0100; pat[2] = 8'h5C; pat[0] = 8'hC3;
    tick();
    req = 4'b0101;
`ifdef LED_SCHED_PREEMPT_EN
    tick();
    check_out("preempt", 4'b0001, 8'hC3, 1'b1, 1'b0);
`else
    for (int i = 2; i <= 8; i++) begin
      tick();
      check_out("nopreempt.hold", 4'b0100, 8'h5C, 1'b1, 1'b0);
    end
    tick();
    check_out("nopreempt.expire", 4'b0001, 8'hC3, 1'b1, 1'b1);
`endif

    // Random traffic against the slice model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) dwell = 24'($urandom_range(0, 6));
      for (int i = 0; i < 4; i++) pat[i] = 8'($urandom);
      @(posedge clk);
      model_step();
      #1;
      check_out("rand", (m_holder < 0) ? 4'b0000 : 4'(1 << m_holder), m_led,
                m_holder >= 0, m_done);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
